button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 15 +
 rtl/button_conditioner_debounce_channel.sv | 88 ++++++++
 rtl/button_conditioner.sv | 57 +++++
 tb/tb_button_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: channel state encoding
// and the default debounce length.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } chan_state_e;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, press/release debounce FSM
// and a single-cycle request on the edge that accepts a press.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_n,
  output logic fire
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_reg;
  chan_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             pressed;

  assign pressed = ~sync_reg[1];
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_reg  <= 2'b11;
      state_reg <= RELEASED;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], btn_n};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The edge that would bring the count to DEBOUNCE_CYCLES is the accepting
  // edge, so the request is raised alongside the move into HELD.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fire       = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (pressed) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          fire       = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the Enter/Change pushbuttons and code switches into registered
// single-cycle pulses with a code snapshot taken on the pulse edge.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int X_W             = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enter_n,
  input  logic           Change_n,
  input  logic [X_W-1:0] X,
  output logic           EnterP,
  output logic           ChangeP,
  output logic [X_W-1:0] XP
);

  logic           enter_fire;
  logic           change_fire;
  logic [X_W-1:0] x_sync1_reg;
  logic [X_W-1:0] x_sync2_reg;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .Clock (Clock),
    .Reset (Reset),
    .btn_n (Enter_n),
    .fire  (enter_fire)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_change (
    .Clock (Clock),
    .Reset (Reset),
    .btn_n (Change_n),
    .fire  (change_fire)
  );

  // Enter wins a same-cycle tie; the Change request is simply lost.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x_sync1_reg <= '0;
      x_sync2_reg <= '0;
      EnterP      <= 1'b0;
      ChangeP     <= 1'b0;
      XP          <= '0;
    end else begin
      x_sync1_reg <= X;
      x_sync2_reg <= x_sync1_reg;
      EnterP      <= enter_fire;
      ChangeP     <= change_fire & ~enter_fire;
      if (enter_fire || change_fire) begin
        XP <= x_sync2_reg;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce length.
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int X_W = 4;

  logic           Clock;
  logic           Reset;
  logic           Enter_n;
  logic           Change_n;
  logic [X_W-1:0] X;
  logic           EnterP;
  logic           ChangeP;
  logic [X_W-1:0] XP;

  int n_checks = 0;
  int n_fail   = 0;

  int e_cnt, e_first, c_cnt, c_first, both;
  int tot;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .X_W(X_W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enter_n  (Enter_n),
    .Change_n (Change_n),
    .X        (X),
    .EnterP   (EnterP),
    .ChangeP  (ChangeP),
    .XP       (XP)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  // Runs n edges (numbered from 1), sampling 1 time unit after each edge.
  task automatic run_cycles(input int n, output int ec, output int ef,
                            output int cc, output int cf, output int bt);
    ec = 0; ef = 0; cc = 0; cf = 0; bt = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge Clock);
      #1;
      if (EnterP === 1'b1) begin
        ec++;
        if (ef == 0) ef = i;
      end
      if (ChangeP === 1'b1) begin
        cc++;
        if (cf == 0) cf = i;
      end
      if (EnterP === 1'b1 && ChangeP === 1'b1) bt++;
    end
  endtask

  initial begin
    Reset    = 1'b0;
    Enter_n  = 1'b0;
    Change_n = 1'b0;
    X        = 4'hF;

    // Reset held with buttons pressed and switches set: outputs stay idle
    run_cycles(10, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("rst_enterp", int'(EnterP), 0);
    check_eq("rst_changep", int'(ChangeP), 0);
    check_eq("rst_xp", int'(XP), 0);
    check_eq("rst_pulses", e_cnt + c_cnt, 0);

    Enter_n  = 1'b1;
    Change_n = 1'b1;
    X        = 4'b0000;
    run_cycles(2, e_cnt, e_first, c_cnt, c_first, both);
    Reset = 1'b1;
    run_cycles(4, e_cnt, e_first, c_cnt, c_first, both);

    // Clean press, held 20 cycles
    X       = 4'b0110;
    run_cycles(3, e_cnt, e_first, c_cnt, c_first, both);
    Enter_n = 1'b0;
    run_cycles(20, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("clean_count", e_cnt, 1);
    check_eq("clean_edge", e_first, 6);
    check_eq("clean_changep", c_cnt, 0);
    check_eq("clean_xp", int'(XP), 6);
    Enter_n = 1'b1;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("release_nopulse", e_cnt + c_cnt, 0);

    // Bounce 0,1,0,1 then solid 0
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      Enter_n = k[0];
      run_cycles(1, e_cnt, e_first, c_cnt, c_first, both);
      tot += e_cnt;
    end
    check_eq("bounce_nopulse", tot, 0);
    Enter_n = 1'b0;
    run_cycles(20, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("bounce_count", e_cnt, 1);
    check_eq("bounce_edge", e_first, 6);
    Enter_n = 1'b1;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);

    // Both pressed on the same edge: Enter wins, Change dropped
    X        = 4'b1001;
    run_cycles(3, e_cnt, e_first, c_cnt, c_first, both);
    Enter_n  = 1'b0;
    Change_n = 1'b0;
    run_cycles(20, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("tie_enter_count", e_cnt, 1);
    check_eq("tie_enter_edge", e_first, 6);
    check_eq("tie_change_count", c_cnt, 0);
    check_eq("tie_xp", int'(XP), 9);
    Enter_n  = 1'b1;
    Change_n = 1'b1;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("tie_release_nopulse", e_cnt + c_cnt, 0);
    X        = 4'b0011;
    run_cycles(3, e_cnt, e_first, c_cnt, c_first, both);
    Change_n = 1'b0;
    run_cycles(20, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("change_count", c_cnt, 1);
    check_eq("change_edge", c_first, 6);
    check_eq("change_enter_quiet", e_cnt, 0);
    check_eq("change_xp", int'(XP), 3);
    Change_n = 1'b1;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);

    // Short release glitch while held: still a single pulse
    Enter_n = 1'b0;
    run_cycles(10, e_cnt, e_first, c_cnt, c_first, both);
    tot = e_cnt;
    Enter_n = 1'b1;
    run_cycles(2, e_cnt, e_first, c_cnt, c_first, both);
    tot += e_cnt;
    Enter_n = 1'b0;
    run_cycles(20, e_cnt, e_first, c_cnt, c_first, both);
    tot += e_cnt;
    check_eq("glitch_total", tot, 1);
    Enter_n = 1'b1;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);

    // Reset mid-debounce (count 3), button kept held through reset
    Enter_n = 1'b0;
    run_cycles(5, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("abort_prepulse", e_cnt, 0);
    Reset = 1'b0;
    #1;
    check_eq("abort_rst_enterp", int'(EnterP), 0);
    run_cycles(3, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("abort_in_reset", e_cnt, 0);
    Reset = 1'b1;
    run_cycles(20, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("abort_fresh_count", e_cnt, 1);
    check_eq("abort_fresh_edge", e_first, 6);
    Enter_n = 1'b1;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);

    // X changes one cycle before the pulse edge: old value captured and held
    X       = 4'b0101;
    run_cycles(3, e_cnt, e_first, c_cnt, c_first, both);
    Enter_n = 1'b0;
    run_cycles(5, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("xlate_prepulse", e_cnt, 0);
    X = 4'b1010;
    run_cycles(1, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("xlate_pulse", e_cnt, 1);
    check_eq("xlate_xp_old", int'(XP), 5);
    run_cycles(10, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("xlate_xp_held", int'(XP), 5);
    Enter_n = 1'b1;
    X       = 4'b1111;
    run_cycles(12, e_cnt, e_first, c_cnt, c_first, both);
    check_eq("xlate_xp_idle", int'(XP), 5);
    check_eq("xlate_idle_nopulse", e_cnt + c_cnt, 0);
    check_eq("never_both", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
